display_arbiter: RTL
====================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters; the supported value is 4 only.
REQ-002 Parameter TICK_DIV, default 100000, is the number of clk cycles per dwell tick (1 ms at 100 MHz).
REQ-003 Parameter DWELL_W, default 16, is the width of dwell_ms.
REQ-004 clk  input  1  system clock, rising-edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-006 req_valid  input  4  per-requester request; held high until ack.
REQ-007 req_data  input  128  requester i word at bits [32i+31:32i].
REQ-008 req_hexbcd  input  4  requester i display mode: 0 = hex, 1 = BCD.
REQ-009 req_dp  input  12  requester i decimal-point selector at bits [3i+2:3i].
REQ-010 dwell_ms  input  DWELL_W  minimum display time per grant, in ticks.
REQ-011 hold  input  1  freezes the dwell count of the current owner.
REQ-012 req_ack  output  4  one-cycle, one-hot acceptance pulse.
REQ-013 display  output  32  word driven to the 8-digit display driver.
REQ-014 hexBCD  output  1  mode driven to the display driver.
REQ-015 dp_selector  output  3  decimal point driven to the display driver.
REQ-016 owner  output  2  index of the last granted requester.
REQ-017 owner_valid  output  1  high once any grant has occurred since reset.

Function
REQ-018 The prescaler shall count 0..TICK_DIV-1 free-running and assert an internal tick for one cycle when count == TICK_DIV-1.
REQ-019 The FSM shall have two states: IDLE (no active dwell) and SHOW (dwell in progress).
REQ-020 In IDLE, if any req_valid is sampled high at edge k, at edge k the winner shall be latched (display, hexBCD, dp_selector, owner), req_ack[winner] shall rise for exactly one cycle, owner_valid shall set, and the FSM shall enter SHOW with the dwell counter at 0.
REQ-021 The winner shall be the first requester with req_valid high, searching upward modulo 4 from (owner+1); before the first grant the search starts at index 0.
REQ-022 In SHOW, the dwell counter shall increment on each tick while hold is low; when a tick arrives with counter == max(dwell_ms,1)-1 and hold low, the FSM shall return to IDLE.
REQ-023 dwell_ms == 0 shall behave as 1; dwell_ms shall be sampled live (not latched), and a value at or below the current count shall end SHOW at the next qualifying tick.
REQ-024 A grant shall never issue in SHOW; requests arriving in SHOW shall wait, and the same requester may win consecutively only if it is the sole valid requester.
REQ-025 A requester that drops req_valid before ack shall not be granted; requests dropped during SHOW have no effect on the latched content.
REQ-026 In IDLE with no valid request, all display outputs shall hold their last values.
REQ-027 The dwell counter shall be DWELL_W bits wide and shall not wrap, because exit occurs at dwell-1.

Reset
REQ-028 While reset_n is low: state = IDLE, prescaler = 0, dwell counter = 0, display = 0, hexBCD = 0, dp_selector = 0, owner = 3 (so the first search starts at 0), owner_valid = 0, req_ack = 0.
REQ-029 Reset asserted mid-SHOW or mid-ack shall abort immediately; the pending grant is lost, and the requester's continued req_valid is re-arbitrated after release.

Structure
REQ-030 The shared package display_pkg shall hold the N_REQ and TICK_DIV defaults, the state enum (IDLE, SHOW), and the field-width constants (32-bit word, 3-bit dp).
REQ-031 Round-robin selection shall be a combinational sub-module rr_arbiter (inputs: valid[3:0], last[1:0]; outputs: grant index, any).
REQ-032 All outputs shall be registered; display, hexBCD, and dp_selector shall connect directly to the existing eight-digit display driver.

Verification (TICK_DIV = 4)
REQ-033 Reset release, req_valid = 4'b0010, req_data[63:32] = 32'h0000_1234, dwell_ms = 3 -> req_ack = 4'b0010 for one cycle, display = 32'h1234, owner = 1, owner_valid = 1; IDLE again after 3 ticks.
REQ-034 req_valid = 4'b1111 held continuously, dwell_ms = 1 -> grant order 0, 1, 2, 3, 0, with one ack per SHOW period.
REQ-035 During SHOW with dwell_ms = 2, assert hold for 10 ticks -> no return to IDLE; after hold drops, IDLE follows 2 further ticks from the frozen count.
REQ-036 dwell_ms = 0, single requester 2 held valid -> requester 2 is re-granted every tick (once per 4 clk cycles), and display is stable between grants.
REQ-037 Requester 3 pulses req_valid during SHOW of requester 0, then drops it before SHOW ends -> requester 3 is never acked, and display keeps requester 0's word.
REQ-038 Assert reset_n = 0 during SHOW of requester 2 -> all outputs reach reset values asynchronously; after release with req_valid = 4'b0100, requester 2 is granted first.

Source files
------------

// File: rtl/display_pkg.sv
// Shared defaults, field widths and FSM state type for the display arbiter.
package display_pkg;

  localparam int unsigned N_REQ_DEFAULT    = 4;
  localparam int unsigned TICK_DIV_DEFAULT = 100000;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned DP_W             = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick for four requesters: first valid index
// searching upward (mod 4) from last+1, with last itself lowest priority.
module rr_arbiter (
  input  logic [3:0] i_valid,
  input  logic [1:0] i_last,
  output logic [1:0] o_grant,
  output logic       o_any
);

  always_comb begin
    o_grant = 2'd0;
    o_any   = |i_valid;
    // Walk from farthest to nearest so the nearest valid index wins.
    for (int i = 4; i >= 1; i--) begin
      if (i_valid[2'(i_last + 2'(i))]) begin
        o_grant = 2'(i_last + 2'(i));
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the eight-digit display: each grant latches one
// requester's word/mode/dp and holds it for a minimum dwell in ticks.
import display_pkg::*;

module display_arbiter #(
  parameter int unsigned N_REQ    = N_REQ_DEFAULT,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned DWELL_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [WORD_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_hexbcd,
  input  logic [DP_W*N_REQ-1:0]     req_dp,
  input  logic [DWELL_W-1:0]        dwell_ms,
  input  logic                      hold,
  output logic [N_REQ-1:0]          req_ack,
  output logic [WORD_W-1:0]         display,
  output logic                      hexBCD,
  output logic [DP_W-1:0]           dp_selector,
  output logic [1:0]                owner,
  output logic                      owner_valid
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e               r_state, w_state_d;
  logic [PRESC_W-1:0]   r_presc;
  logic [DWELL_W-1:0]   r_dwell, w_dwell_d;
  logic [N_REQ-1:0]     r_ack;
  logic [WORD_W-1:0]    r_display;
  logic                 r_hexbcd;
  logic [DP_W-1:0]      r_dp;
  logic [1:0]           r_owner;
  logic                 r_owner_valid;

  logic                 w_tick;
  logic [1:0]           w_grant;
  logic                 w_any;
  logic                 w_load;
  logic [DWELL_W-1:0]   w_lim;
  logic                 w_at_end;

  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  rr_arbiter u_rr (
    .i_valid (req_valid),
    .i_last  (r_owner),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  // dwell_ms is live; a zero dwell acts as one tick, and a shrunken dwell
  // at or below the running count ends SHOW on the next qualifying tick.
  assign w_lim    = (dwell_ms == '0) ? DWELL_W'(1) : dwell_ms;
  assign w_at_end = (r_dwell >= (w_lim - DWELL_W'(1)));

  always_comb begin
    w_state_d = r_state;
    w_dwell_d = r_dwell;
    w_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load    = 1'b1;
          w_state_d = SHOW;
          w_dwell_d = '0;
        end
      end
      SHOW: begin
        if (w_tick && !hold) begin
          if (w_at_end) begin
            w_state_d = IDLE;
            w_dwell_d = '0;
          end else begin
            w_dwell_d = r_dwell + 1'b1;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_dwell       <= '0;
      r_ack         <= '0;
      r_display     <= '0;
      r_hexbcd      <= 1'b0;
      r_dp          <= '0;
      r_owner       <= 2'd3;
      r_owner_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_dwell <= w_dwell_d;
      r_ack   <= w_load ? (N_REQ'(1) << w_grant) : '0;
      if (w_load) begin
        r_display     <= req_data[w_grant*WORD_W +: WORD_W];
        r_hexbcd      <= req_hexbcd[w_grant];
        r_dp          <= req_dp[w_grant*DP_W +: DP_W];
        r_owner       <= w_grant;
        r_owner_valid <= 1'b1;
      end
    end
  end

  assign req_ack     = r_ack;
  assign display     = r_display;
  assign hexBCD      = r_hexbcd;
  assign dp_selector = r_dp;
  assign owner       = r_owner;
  assign owner_valid = r_owner_valid;

endmodule
